// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and helpers for the two-requester AXI3 write arbiter.
package axi_wr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_wr_order_fifo.sv
// Small ordering FIFO that records which requester owns each accepted burst.
module axi_wr_order_fifo
  import axi_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // A pop on empty is ignored, so a coincident push lands at the head.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_q == PW'(gi))) mem_q[gi] <= din;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI3 write arbiter: two requesters onto one master, with W and B
// steered by the order in which AW bursts were accepted.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ORDER_DEPTH    = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ID_WIDTH-1:0]       s0_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s0_axi_awaddr,
  input  logic [3:0]                    s0_axi_awlen,
  input  logic [2:0]                    s0_axi_awsize,
  input  logic [1:0]                    s0_axi_awburst,
  input  logic [3:0]                    s0_axi_awcache,
  input  logic                          s0_axi_awvalid,
  output logic                          s0_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]       s0_axi_wid,
  input  logic [AXI_DATA_WIDTH-1:0]     s0_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s0_axi_wstrb,
  input  logic                          s0_axi_wlast,
  input  logic                          s0_axi_wvalid,
  output logic                          s0_axi_wready,
  output logic                          s0_axi_bvalid,
  input  logic                          s0_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]       s1_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s1_axi_awaddr,
  input  logic [3:0]                    s1_axi_awlen,
  input  logic [2:0]                    s1_axi_awsize,
  input  logic [1:0]                    s1_axi_awburst,
  input  logic [3:0]                    s1_axi_awcache,
  input  logic                          s1_axi_awvalid,
  output logic                          s1_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]       s1_axi_wid,
  input  logic [AXI_DATA_WIDTH-1:0]     s1_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s1_axi_wstrb,
  input  logic                          s1_axi_wlast,
  input  logic                          s1_axi_wvalid,
  output logic                          s1_axi_wready,
  output logic                          s1_axi_bvalid,
  input  logic                          s1_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [3:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [3:0]                    m_axi_awcache,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  // Assert asynchronously, release two edges after aresetn rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  arb_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       prio_q, prio_d;   // requester favoured when both are valid
  logic       aw_hs, w_pop, b_pop;
  logic       w_head, w_empty, w_full;
  logic       b_head, b_empty, b_full;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    prio_d         = prio_q;
    m_axi_awvalid  = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    aw_hs          = 1'b0;
    case (state_q)
      IDLE: begin
        if ((s0_axi_awvalid || s1_axi_awvalid) && !w_full && !b_full) begin
          state_d = BUSY;
          gnt_d   = (s0_axi_awvalid && s1_axi_awvalid) ? prio_q : s1_axi_awvalid;
        end
      end
      BUSY: begin
        m_axi_awvalid  = gnt_q ? s1_axi_awvalid : s0_axi_awvalid;
        s0_axi_awready = ~gnt_q & m_axi_awready;
        s1_axi_awready = gnt_q & m_axi_awready;
        aw_hs          = m_axi_awvalid & m_axi_awready;
        if (aw_hs) begin
          state_d = IDLE;
          prio_d  = ~gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end

  assign m_axi_awid    = gnt_q ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr  = gnt_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen   = gnt_q ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize  = gnt_q ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst = gnt_q ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awcache = gnt_q ? s1_axi_awcache : s0_axi_awcache;

  // Write data is only released once its burst owns the head of the W order.
  assign m_axi_wid     = w_head ? s1_axi_wid   : s0_axi_wid;
  assign m_axi_wdata   = w_head ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb   = w_head ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast   = w_head ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid  = ~w_empty & (w_head ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready = ~w_empty & ~w_head & m_axi_wready;
  assign s1_axi_wready = ~w_empty & w_head & m_axi_wready;
  assign w_pop         = m_axi_wvalid & m_axi_wready & m_axi_wlast;

  assign s0_axi_bvalid = ~b_empty & ~b_head & m_axi_bvalid;
  assign s1_axi_bvalid = ~b_empty & b_head & m_axi_bvalid;
  assign m_axi_bready  = ~b_empty & (b_head ? s1_axi_bready : s0_axi_bready);
  assign b_pop         = m_axi_bvalid & m_axi_bready;

  axi_wr_order_fifo #(.DEPTH(ORDER_DEPTH), .WIDTH(1)) u_w_order (
    .clk   (aclk),
    .rst_n (rst_n),
    .push  (aw_hs),
    .pop   (w_pop),
    .din   (gnt_q),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  axi_wr_order_fifo #(.DEPTH(ORDER_DEPTH), .WIDTH(1)) u_b_order (
    .clk   (aclk),
    .rst_n (rst_n),
    .push  (aw_hs),
    .pop   (b_pop),
    .din   (gnt_q),
    .dout  (b_head),
    .empty (b_empty),
    .full  (b_full)
  );

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed corner cases followed by randomized traffic against a queue-based ordering model.
module tb_axi_wr_arbiter;

  localparam int IDW = 6;
  localparam int ADW = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int NB  = 12;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [IDW-1:0] awid [2];
  logic [ADW-1:0] awaddr [2];
  logic [3:0]     awlen [2];
  logic [2:0]     awsize [2];
  logic [1:0]     awburst [2];
  logic [3:0]     awcache [2];
  logic [IDW-1:0] wid [2];
  logic [DW-1:0]  wdata [2];
  logic [SW-1:0]  wstrb [2];
  logic [1:0]     awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  logic [IDW-1:0] m_awid, m_wid;
  logic [ADW-1:0] m_awaddr;
  logic [3:0]     m_awlen, m_awcache;
  logic [2:0]     m_awsize;
  logic [1:0]     m_awburst;
  logic [DW-1:0]  m_wdata;
  logic [SW-1:0]  m_wstrb;
  logic           m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  axi_wr_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_awid(awid[0]), .s0_axi_awaddr(awaddr[0]), .s0_axi_awlen(awlen[0]),
    .s0_axi_awsize(awsize[0]), .s0_axi_awburst(awburst[0]), .s0_axi_awcache(awcache[0]),
    .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
    .s0_axi_wid(wid[0]), .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]), .s0_axi_wlast(wlast[0]),
    .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
    .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
    .s1_axi_awid(awid[1]), .s1_axi_awaddr(awaddr[1]), .s1_axi_awlen(awlen[1]),
    .s1_axi_awsize(awsize[1]), .s1_axi_awburst(awburst[1]), .s1_axi_awcache(awcache[1]),
    .s1_axi_awvalid(awvalid[1]), .s1_axi_awready(awready[1]),
    .s1_axi_wid(wid[1]), .s1_axi_wdata(wdata[1]), .s1_axi_wstrb(wstrb[1]), .s1_axi_wlast(wlast[1]),
    .s1_axi_wvalid(wvalid[1]), .s1_axi_wready(wready[1]),
    .s1_axi_bvalid(bvalid[1]), .s1_axi_bready(bready[1]),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awcache(m_awcache),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wid(m_wid), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({awready, wready, bvalid, m_awvalid, m_wvalid, m_bready});
  endfunction

  task automatic idle_inputs();
    for (int r = 0; r < 2; r++) begin
      awid[r] = '0; awaddr[r] = '0; awlen[r] = '0; awsize[r] = '0;
      awburst[r] = '0; awcache[r] = '0; wid[r] = '0; wdata[r] = '0; wstrb[r] = '0;
    end
    awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
  endtask

  // Burst tables for the random phase
  logic [IDW-1:0] t_id    [2][NB];
  logic [ADW-1:0] t_addr  [2][NB];
  logic [3:0]     t_cache [2][NB];
  logic [DW-1:0]  t_base  [2][NB];
  logic [SW-1:0]  t_strb  [2][NB];
  int             t_len   [2][NB];

  // Reference ordering model: owners of accepted bursts still awaiting W / B
  int w_order_q[$];
  int b_order_q[$];

  int  aw_i[2], w_b[2], w_beat[2], wexp_b[2], wexp_beat[2], done[2];
  int  slave_tok, last_src, src, h, k, n_aw, eb, ebt, cyc;
  int  gsrc[8], gcyc[8];
  bit  cont[2];
  bit  aw_seen, w_seen;
  logic [1:0] aw_hs, w_hs, exp_wr, exp_bv;
  logic       b_hs, exp_mwv, exp_mbr;

  initial begin
    // ---------------- reset: outputs stay low despite active inputs
    idle_inputs();
    aresetn = 1'b0;
    awvalid = 2'b11; wvalid = 2'b11; bready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    #23;
    check("reset_outputs", outs(), 64'(0));
    idle_inputs();
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;

    // ---------------- orphan B response and early W are both held
    m_bvalid = 1'b1; bready = 2'b11; wvalid = 2'b11; wlast = 2'b11; m_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("orphan_b_held", 64'({m_bready, bvalid}), 64'(0));
      check("early_w_stalled", 64'({m_wvalid, wready}), 64'(0));
    end
    @(posedge aclk); #1;

    // ---------------- s1 presents W three cycles before its AW
    m_bvalid = 1'b0; bready = 2'b00; wvalid = 2'b10; wlast = 2'b10;
    wid[1] = 6'h25; wdata[1] = 64'hA5A5_0F0F_1234_5678; wstrb[1] = 8'h3C;
    awid[1] = 6'h25; awaddr[1] = 32'h0000_1000; awlen[1] = 4'd0; awsize[1] = 3'd3; awburst[1] = 2'd1;
    m_awready = 1'b1; m_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("w_before_aw_stalled", 64'(wready[1]), 64'(0));
      @(posedge aclk); #1;
    end
    awvalid[1] = 1'b1;
    aw_seen = 1'b0; w_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      check("w_waits_for_aw", 64'(wready[1]), 64'(aw_seen && !w_seen));
      if (awvalid[1] && awready[1]) begin
        aw_seen = 1'b1;
        check("aw_payload_s1", 64'({m_awid, m_awaddr, m_awlen}), 64'({6'h25, 32'h0000_1000, 4'd0}));
      end
      if (wvalid[1] && wready[1]) begin
        w_seen = 1'b1;
        check("w_data_s1", m_wdata, 64'hA5A5_0F0F_1234_5678);
        check("w_ctl_s1", 64'({m_wid, m_wstrb, m_wlast}), 64'({6'h25, 8'h3C, 1'b1}));
      end
      @(posedge aclk); #1;
      if (aw_seen) awvalid[1] = 1'b0;
      if (w_seen)  wvalid[1]  = 1'b0;
    end
    check("early_w_completed", 64'({aw_seen, w_seen}), 64'(2'b11));

    // ---------------- B goes to s1 exactly once, then a repeat is held
    m_bvalid = 1'b1; bready = 2'b10;
    @(negedge aclk);
    check("b_route_s1", 64'({m_bready, bvalid}), 64'(3'b110));
    @(posedge aclk); #1;
    @(negedge aclk);
    check("b_after_pop_held", 64'({m_bready, bvalid}), 64'(0));
    @(posedge aclk); #1;
    m_bvalid = 1'b0; bready = 2'b00;

    // ---------------- both requesting: alternation, spacing, FIFO-full stall
    m_wready = 1'b0; m_awready = 1'b1; awid[0] = 6'h01; awid[1] = 6'h21; awvalid = 2'b11;
    n_aw = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge aclk);
      if (m_awvalid && m_awready) begin
        if (n_aw < 8) begin
          gsrc[n_aw] = (awready == 2'b10) ? 1 : ((awready == 2'b01) ? 0 : 9);
          gcyc[n_aw] = c;
        end
        n_aw++;
      end
    end
    check("aw_accept_until_full", 64'(n_aw), 64'(4));
    for (int i = 0; i < 4; i++) check("rr_grant_order", 64'(gsrc[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) check("aw_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(2));
    check("full_blocks_aw", 64'(awready), 64'(0));

    // ---------------- reset while s0 is mid-burst
    @(posedge aclk); #1;
    awvalid = 2'b00; wvalid = 2'b01; wlast = 2'b00; wid[0] = 6'h01; m_wready = 1'b1;
    repeat (7) @(posedge aclk);
    #1;
    check("midburst_active", 64'({m_wvalid, wready}), 64'(3'b101));
    #2 aresetn = 1'b0;
    #1 check("reset_async_outputs", outs(), 64'(0));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    m_bvalid = 1'b1; bready = 2'b11; m_awready = 1'b1;
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("post_reset_idle_empty", outs(), 64'(0));

    // ---------------- randomized traffic
    idle_inputs();
    aresetn = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < NB; b++) begin
        t_id[r][b]    = IDW'($urandom_range(0, 31)) | ((r == 1) ? IDW'(32) : IDW'(0));
        t_addr[r][b]  = $urandom;
        t_cache[r][b] = 4'($urandom_range(0, 15));
        t_base[r][b]  = {$urandom, $urandom};
        t_strb[r][b]  = 8'($urandom_range(0, 255));
        t_len[r][b]   = $urandom_range(0, 7);
      end
      aw_i[r] = 0; w_b[r] = 0; w_beat[r] = 0; wexp_b[r] = 0; wexp_beat[r] = 0; done[r] = 0;
      cont[r] = 1'b1;
    end
    slave_tok = 0; last_src = 1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;

    cyc = 0;
    while (cyc < 20000 && !(done[0] == NB && done[1] == NB)) begin
      cyc++;
      @(negedge aclk);
      exp_wr = 2'b00; exp_bv = 2'b00; exp_mwv = 1'b0; exp_mbr = 1'b0;
      if (w_order_q.size() > 0) begin
        h = w_order_q[0];
        exp_wr[h] = m_wready;
        exp_mwv   = wvalid[h];
      end
      if (b_order_q.size() > 0) begin
        k = b_order_q[0];
        exp_bv[k] = m_bvalid;
        exp_mbr   = bready[k];
      end
      check("w_route", 64'({m_wvalid, wready}), 64'({exp_mwv, exp_wr}));
      check("b_route", 64'({m_bready, bvalid}), 64'({exp_mbr, exp_bv}));

      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      b_hs  = m_bvalid & m_bready;
      for (int r = 0; r < 2; r++) if (!awvalid[r]) cont[r] = 1'b0;

      if (m_wvalid && m_wready) begin
        check("w_has_owner", 64'(w_order_q.size() > 0), 64'(1));
        if (w_order_q.size() > 0) begin
          src = w_order_q[0];
          eb  = wexp_b[src];
          ebt = wexp_beat[src];
          check("w_data", m_wdata, t_base[src][eb] + DW'(ebt));
          check("w_ctl", 64'({m_wid, m_wstrb, m_wlast}),
                64'({t_id[src][eb], t_strb[src][eb] ^ SW'(ebt), ebt == t_len[src][eb]}));
          if (ebt == t_len[src][eb]) begin
            void'(w_order_q.pop_front());
            wexp_b[src]++; wexp_beat[src] = 0;
            slave_tok++;
          end else begin
            wexp_beat[src]++;
          end
        end
      end

      if (m_bvalid && m_bready) begin
        check("b_has_owner", 64'(b_order_q.size() > 0), 64'(1));
        if (b_order_q.size() > 0) begin
          src = b_order_q.pop_front();
          done[src]++;
          $display("B   s%0d response %0d", src, done[src]);
        end
        slave_tok--;
      end

      if (m_awvalid && m_awready) begin
        src = int'(m_awid[IDW-1]);
        eb  = aw_i[src];
        check("aw_ready_owner", 64'(awready), 64'(2'b01 << src));
        check("aw_payload", 64'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache}),
              64'({t_id[src][eb], t_addr[src][eb], 4'(t_len[src][eb]), 3'd3, 2'd1, t_cache[src][eb]}));
        if (cont[1-src]) check("rr_fairness", 64'(src), 64'(1 - last_src));
        $display("AW  s%0d id=%0h addr=%08h len=%0d", src, m_awid, m_awaddr, m_awlen);
        last_src = src;
        cont[0] = 1'b1; cont[1] = 1'b1;
        w_order_q.push_back(src);
        b_order_q.push_back(src);
      end

      @(posedge aclk); #1;
      for (int r = 0; r < 2; r++) begin
        if (aw_hs[r]) begin
          awvalid[r] = 1'b0;
          aw_i[r]++;
        end
        if (!awvalid[r] && aw_i[r] < NB && $urandom_range(0, 2) == 0) begin
          awid[r]    = t_id[r][aw_i[r]];
          awaddr[r]  = t_addr[r][aw_i[r]];
          awlen[r]   = 4'(t_len[r][aw_i[r]]);
          awsize[r]  = 3'd3;
          awburst[r] = 2'd1;
          awcache[r] = t_cache[r][aw_i[r]];
          awvalid[r] = 1'b1;
        end
        if (w_hs[r]) begin
          wvalid[r] = 1'b0;
          if (w_beat[r] == t_len[r][w_b[r]]) begin
            w_b[r]++; w_beat[r] = 0;
          end else begin
            w_beat[r]++;
          end
        end
        if (!wvalid[r] && w_b[r] < NB && $urandom_range(0, 3) != 0) begin
          wid[r]    = t_id[r][w_b[r]];
          wdata[r]  = t_base[r][w_b[r]] + DW'(w_beat[r]);
          wstrb[r]  = t_strb[r][w_b[r]] ^ SW'(w_beat[r]);
          wlast[r]  = (w_beat[r] == t_len[r][w_b[r]]);
          wvalid[r] = 1'b1;
        end
        bready[r] = 1'($urandom_range(0, 1));
      end
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = ($urandom_range(0, 3) != 0);
      if (b_hs) m_bvalid = 1'b0;
      if (!m_bvalid && slave_tok > 0 && $urandom_range(0, 1) == 1) m_bvalid = 1'b1;
    end

    check("done_s0", 64'(done[0]), 64'(NB));
    check("done_s1", 64'(done[1]), 64'(NB));
    check("orders_drained", 64'(w_order_q.size() + b_order_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
